// File: rtl/cache_line_controller.sv
// Miss-handling FSM for a direct-mapped cache: hits, dirty-victim writeback, word-by-word fill, tag install.
// Optional event counters are enabled by defining CACHE_STATS_EN; otherwise stat_* are tied to 0.
module cache_line_controller #(
    parameter int unsigned LINE_WORDS = 4,
    parameter bit          READ_ONLY  = 1'b0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    input  logic                          req_we,
    input  logic                          hit,
    input  logic                          victim_dirty,
    input  logic                          mem_ack,
    output logic                          req_done,
    output logic                          busy,
    output logic                          clear_selected_valid_bit,
    output logic                          finish_new_line_install,
    output logic                          clear_selected_dirty_bit,
    output logic                          set_selected_dirty_bit,
    output logic                          mem_req_valid,
    output logic                          mem_we,
    output logic                          mem_addr_victim,
    output logic [$clog2(LINE_WORDS)-1:0] word_idx,
    output logic                          data_we,
    output logic                          data_fill_sel,
    output logic [31:0]                   stat_hits,
    output logic [31:0]                   stat_misses,
    output logic [31:0]                   stat_wbacks
);
    localparam int unsigned   IW       = $clog2(LINE_WORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITEBACK,
        S_FILL,
        S_INSTALL
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] word_idx_q, word_idx_d;
    logic          dirty_miss, store_hit, last_word;

    // In an instruction cache the dirty bit and store flag are meaningless.
    assign dirty_miss = victim_dirty && !READ_ONLY;
    assign store_hit  = req_we && !READ_ONLY;
    assign last_word  = (word_idx_q == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            word_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid && !hit) begin
                    state_d    = dirty_miss ? S_WRITEBACK : S_FILL;
                    word_idx_d = '0;
                end
            end
            S_WRITEBACK: begin
                if (mem_ack) begin
                    word_idx_d = word_idx_q + IW'(1);
                    if (last_word) state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (mem_ack) begin
                    word_idx_d = word_idx_q + IW'(1);
                    if (last_word) state_d = S_INSTALL;
                end
            end
            S_INSTALL: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_done                 = 1'b0;
        clear_selected_valid_bit = 1'b0;
        finish_new_line_install  = 1'b0;
        clear_selected_dirty_bit = 1'b0;
        set_selected_dirty_bit   = 1'b0;
        mem_req_valid            = 1'b0;
        mem_we                   = 1'b0;
        mem_addr_victim          = 1'b0;
        data_we                  = 1'b0;
        data_fill_sel            = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid && hit) begin
                    req_done               = 1'b1;
                    data_we                = store_hit;
                    set_selected_dirty_bit = store_hit;
                end else if (req_valid && !dirty_miss) begin
                    clear_selected_valid_bit = 1'b1;
                end
            end
            S_WRITEBACK: begin
                mem_req_valid   = 1'b1;
                mem_we          = 1'b1;
                mem_addr_victim = 1'b1;
                if (mem_ack && last_word) begin
                    clear_selected_valid_bit = 1'b1;
                    clear_selected_dirty_bit = !READ_ONLY;
                end
            end
            S_FILL: begin
                mem_req_valid = 1'b1;
                data_we       = mem_ack;
                data_fill_sel = mem_ack;
            end
            S_INSTALL: begin
                finish_new_line_install  = 1'b1;
                clear_selected_dirty_bit = !READ_ONLY;
            end
            default: ;
        endcase
    end

    assign busy     = (state_q != S_IDLE);
    assign word_idx = word_idx_q;

`ifdef CACHE_STATS_EN
    logic [31:0] hits_q, misses_q, wbacks_q;
    logic        miss_evt, wback_evt;

    assign miss_evt  = (state_q == S_IDLE) && (state_d != S_IDLE);
    assign wback_evt = (state_q == S_WRITEBACK) && (state_d == S_FILL);

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            hits_q   <= '0;
            misses_q <= '0;
            wbacks_q <= '0;
        end else begin
            if (req_done && hits_q != '1)    hits_q   <= hits_q + 32'd1;
            if (miss_evt && misses_q != '1)  misses_q <= misses_q + 32'd1;
            if (wback_evt && wbacks_q != '1) wbacks_q <= wbacks_q + 32'd1;
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
    assign stat_wbacks = wbacks_q;
`else
    assign stat_hits   = '0;
    assign stat_misses = '0;
    assign stat_wbacks = '0;
`endif

endmodule
